// File: rtl/async_op_pkg.sv
// async_op_pkg: opcodes, per-input handshake states and the operator evaluation
// shared between the dataflow node RTL and the graph generator.
package async_op_pkg;

  localparam int OP_PASS = 0;
  localparam int OP_ADD  = 1;
  localparam int OP_SUB  = 2;
  localparam int OP_MUL  = 3;
  localparam int OP_ADDI = 4;
  localparam int OP_SUBI = 5;
  localparam int OP_MULI = 6;

  localparam int OP_MAX_DW = 64;
  localparam int OP_MAX_IN = 4;

  typedef logic [OP_MAX_DW-1:0]                 op_word_t;
  typedef logic [OP_MAX_IN-1:0][OP_MAX_DW-1:0]  op_vec_t;

  typedef enum logic [1:0] {
    IN_IDLE = 2'd0,
    IN_REQ  = 2'd1,
    IN_HAS  = 2'd2
  } in_state_e;

  // Computed at OP_MAX_DW bits; truncating the result keeps it modulo 2^DATA_WIDTH.
  function automatic op_word_t op_eval(input int       op,
                                       input op_word_t imm,
                                       input op_vec_t  operands,
                                       input int       n_in);
    op_word_t acc;
    acc = operands[0];
    case (op)
      OP_ADD: begin
        for (int i = 1; i < OP_MAX_IN; i++) begin
          if (i < n_in) acc = acc + operands[i];
        end
      end
      OP_SUB: begin
        for (int i = 1; i < OP_MAX_IN; i++) begin
          if (i < n_in) acc = acc - operands[i];
        end
      end
      OP_MUL: begin
        for (int i = 1; i < OP_MAX_IN; i++) begin
          if (i < n_in) acc = acc * operands[i];
        end
      end
      OP_ADDI: acc = operands[0] + imm;
      OP_SUBI: acc = operands[0] - imm;
      OP_MULI: acc = operands[0] * imm;
      default: acc = operands[0];
    endcase
    return acc;
  endfunction

endpackage

// File: rtl/async_op_fifo.sv
// async_op_fifo: DEPTH x DATA_WIDTH result buffer; read data is the head entry,
// forced to zero while empty. A push into a full FIFO is dropped even if a pop coincides.
module async_op_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [DATA_WIDTH-1:0]  wdata_i,
  output logic [DATA_WIDTH-1:0]  rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an emptied FIFO never exposes stale entries.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/async_operator_buffered.sv
// async_operator_buffered: dataflow operator node with pull-handshake operands, a result FIFO
// and M-way broadcast fanout. Define ASYNC_OP_STATS_EN to add fire_cnt/stall_cnt counters.
module async_operator_buffered
  import async_op_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    INPUT_SIZE  = 2,
  parameter int                    OUTPUT_SIZE = 1,
  parameter int                    DEPTH       = 4,
  parameter int                    OP          = OP_ADD,
  parameter logic [DATA_WIDTH-1:0] IMMEDIATE   = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  output logic [INPUT_SIZE-1:0]            req_l,
  input  logic [INPUT_SIZE-1:0]            ack_l,
  input  logic [DATA_WIDTH*INPUT_SIZE-1:0] din,
  input  logic [OUTPUT_SIZE-1:0]           req_r,
  output logic [OUTPUT_SIZE-1:0]           ack_r,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic [$clog2(DEPTH):0]           count
`ifdef ASYNC_OP_STATS_EN
  ,
  output logic [31:0]                      fire_cnt,
  output logic [31:0]                      stall_cnt
`endif
);

  if (INPUT_SIZE < 1 || INPUT_SIZE > OP_MAX_IN || DATA_WIDTH > OP_MAX_DW ||
      OUTPUT_SIZE < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
    $error("async_operator_buffered: unsupported parameter combination");
  end

  in_state_e              state_q [INPUT_SIZE];
  in_state_e              state_d [INPUT_SIZE];
  logic [DATA_WIDTH-1:0]  opnd_q  [INPUT_SIZE];
  logic [DATA_WIDTH-1:0]  opnd_d  [INPUT_SIZE];
  logic [INPUT_SIZE-1:0]  has;
  logic                   all_has;
  logic                   fire;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [DATA_WIDTH-1:0]  result;
  op_vec_t                ops_v;
  logic [OUTPUT_SIZE-1:0] ack_q, ack_d;
  logic [OUTPUT_SIZE-1:0] served_q, served_d;

  always_comb begin
    has   = '0;
    req_l = '0;
    for (int i = 0; i < INPUT_SIZE; i++) begin
      has[i]   = (state_q[i] == IN_HAS);
      req_l[i] = (state_q[i] == IN_REQ);
    end
  end

  // Firing needs a free slot; a pop on the same edge does not open one.
  assign all_has = &has;
  assign fire    = all_has & ~fifo_full;

  always_comb begin
    for (int i = 0; i < INPUT_SIZE; i++) begin
      state_d[i] = state_q[i];
      opnd_d[i]  = opnd_q[i];
      case (state_q[i])
        IN_IDLE: state_d[i] = IN_REQ;
        IN_REQ: begin
          if (ack_l[i]) begin
            state_d[i] = IN_HAS;
            opnd_d[i]  = din[DATA_WIDTH*i +: DATA_WIDTH];
          end
        end
        IN_HAS: begin
          if (fire) state_d[i] = IN_IDLE;
        end
        default: state_d[i] = IN_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < INPUT_SIZE; i++) begin
        state_q[i] <= IN_IDLE;
        opnd_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < INPUT_SIZE; i++) begin
        state_q[i] <= state_d[i];
        opnd_q[i]  <= opnd_d[i];
      end
    end
  end

  always_comb begin
    ops_v = '0;
    for (int i = 0; i < INPUT_SIZE; i++) begin
      ops_v[i] = OP_MAX_DW'(opnd_q[i]);
    end
    result = DATA_WIDTH'(op_eval(OP, OP_MAX_DW'(IMMEDIATE), ops_v, INPUT_SIZE));
  end

  async_op_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fire),
    .pop_i   (pop),
    .wdata_i (result),
    .rdata_o (dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  // served[j] is set together with ack_r[j], so the head only pops once every
  // consumer's ack pulse has been seen with the head still on dout.
  always_comb begin
    pop      = ~fifo_empty & (&served_q);
    ack_d    = req_r & ~served_q & ~ack_q & {OUTPUT_SIZE{~fifo_empty}};
    served_d = pop ? '0 : (served_q | ack_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_q    <= '0;
      served_q <= '0;
    end else begin
      ack_q    <= ack_d;
      served_q <= served_d;
    end
  end

  assign ack_r = ack_q;

`ifdef ASYNC_OP_STATS_EN
  logic [31:0] fire_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fire_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fire && fire_cnt_q != '1) fire_cnt_q <= fire_cnt_q + 32'd1;
      if (all_has && fifo_full && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fire_cnt  = fire_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_async_operator_buffered.sv
// Bench for async_operator_buffered: dutA is a 3-input SUB node with two consumers (8-bit),
// dutB a 2-input ADD node with one consumer (32-bit). Results are checked through scoreboards.
`timescale 1ns/1ps
module tb_async_operator_buffered;
  import async_op_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int assertCount = 0;
  int failCount   = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // dutA signals and stimulus store
  logic        rstA_n = 1'b0;
  logic [2:0]  aReqL;
  logic [2:0]  aAckL = '0;
  logic [23:0] aDin  = '0;
  logic [1:0]  aReqR = '0;
  logic [1:0]  aAckR;
  logic [7:0]  aDout;
  logic [2:0]  aCount;
  logic [7:0]  aOps [64][3];
  int          aWr = 0;
  int          aRd [3] = '{default: 0};
  logic [2:0]  aMask = 3'b111;
  logic        aFlushReq = 1'b0;
  logic        aFlushAck = 1'b0;
  logic [7:0]  expA0 [$];
  logic [7:0]  expA1 [$];
  int          aAckCnt0 = 0;
  int          aAckCnt1 = 0;

  // dutB signals and stimulus store
  logic        rstB_n = 1'b0;
  logic [1:0]  bReqL;
  logic [1:0]  bAckL = '0;
  logic [63:0] bDin  = '0;
  logic        bReqR = 1'b0;
  logic        bAckR;
  logic [31:0] bDout;
  logic [2:0]  bCount;
  logic [31:0] bOps [64][2];
  int          bWr = 0;
  int          bRd [2] = '{default: 0};
  logic [31:0] expB [$];
  int          bCapCyc = 0;
  int          bMaxCnt = 0;
  logic        bPrevAck = 1'b0;
  logic        bFirst = 1'b1;

`ifdef ASYNC_OP_STATS_EN
  logic [31:0] aFireCnt, aStallCnt, bFireCnt, bStallCnt;
`endif

  async_operator_buffered #(
    .DATA_WIDTH(8), .INPUT_SIZE(3), .OUTPUT_SIZE(2), .DEPTH(4), .OP(OP_SUB), .IMMEDIATE(8'd0)
  ) dutA (
    .clk(clk), .rst_n(rstA_n), .req_l(aReqL), .ack_l(aAckL), .din(aDin),
    .req_r(aReqR), .ack_r(aAckR), .dout(aDout), .count(aCount)
`ifdef ASYNC_OP_STATS_EN
    , .fire_cnt(aFireCnt), .stall_cnt(aStallCnt)
`endif
  );

  async_operator_buffered #(
    .DATA_WIDTH(32), .INPUT_SIZE(2), .OUTPUT_SIZE(1), .DEPTH(4), .OP(OP_ADD), .IMMEDIATE(32'd0)
  ) dutB (
    .clk(clk), .rst_n(rstB_n), .req_l(bReqL), .ack_l(bAckL), .din(bDin),
    .req_r(bReqR), .ack_r(bAckR), .dout(bDout), .count(bCount)
`ifdef ASYNC_OP_STATS_EN
    , .fire_cnt(bFireCnt), .stall_cnt(bStallCnt)
`endif
  );

  // Upstream producers: answer a request with a one-cycle ack carrying the next stored operand.
  always @(negedge clk) begin
    if (aFlushReq != aFlushAck) begin
      for (int i = 0; i < 3; i++) aRd[i] = aWr;
      aFlushAck = aFlushReq;
    end
    for (int i = 0; i < 3; i++) begin
      if (aReqL[i] && aMask[i] && aRd[i] < aWr) begin
        aAckL[i] = 1'b1;
        aDin[8*i +: 8] = aOps[aRd[i]][i];
        aRd[i] = aRd[i] + 1;
      end else begin
        aAckL[i] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (bReqL[i] && bRd[i] < bWr) begin
        bAckL[i] = 1'b1;
        bDin[32*i +: 32] = bOps[bRd[i]][i];
        bRd[i] = bRd[i] + 1;
        bCapCyc = cyc + 1;
      end else begin
        bAckL[i] = 1'b0;
      end
    end
  end

  // Consumer-side monitors: every ack pulse pops that consumer's expected queue.
  always @(negedge clk) begin
    if (aAckR[0]) begin
      aAckCnt0++;
      checkOutput("A c0 pending", expA0.size() > 0, 1);
      if (expA0.size() > 0) checkOutput("A c0 dout", aDout, expA0.pop_front());
    end
    if (aAckR[1]) begin
      aAckCnt1++;
      checkOutput("A c1 pending", expA1.size() > 0, 1);
      if (expA1.size() > 0) checkOutput("A c1 dout", aDout, expA1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (int'(bCount) > bMaxCnt) bMaxCnt = int'(bCount);
    if (bAckR) begin
      checkOutput("B ack spacing", bPrevAck, 0);
      checkOutput("B pending", expB.size() > 0, 1);
      if (expB.size() > 0) checkOutput("B dout", bDout, expB.pop_front());
      if (bFirst) begin
        checkOutput("B latency", cyc - bCapCyc, 2);
        bFirst = 1'b0;
      end
    end
    bPrevAck = bAckR;
  end

  task automatic applyStimulus(input bit toB, input logic [31:0] x0, x1, x2, input bit keep);
    logic [7:0]  e8;
    logic [31:0] e32;
    if (toB) begin
      bOps[bWr][0] = x0;
      bOps[bWr][1] = x1;
      bWr++;
      e32 = x0 + x1;
      if (keep) expB.push_back(e32);
    end else begin
      aOps[aWr][0] = x0[7:0];
      aOps[aWr][1] = x1[7:0];
      aOps[aWr][2] = x2[7:0];
      aWr++;
      e8 = x0[7:0] - x1[7:0] - x2[7:0];
      if (keep) begin
        expA0.push_back(e8);
        expA1.push_back(e8);
      end
    end
  endtask

  task automatic waitDrain(input bit isB, input int limit, input string tag);
    int k;
    k = 0;
    while (k < limit && (isB ? (expB.size() != 0) : (expA0.size() != 0 || expA1.size() != 0))) begin
      @(negedge clk);
      k++;
    end
    checkOutput(tag, k < limit, 1);
  endtask

  initial begin
    int k;
    int c0Start;
    int c1Start;
    logic [31:0] x;
    logic [31:0] y;
`ifdef ASYNC_OP_STATS_EN
    logic [31:0] s0;
    logic [31:0] sd;
`endif
    repeat (3) @(negedge clk);
    checkOutput("A reset count", aCount, 0);
    checkOutput("A reset ack_r", aAckR, 0);
    checkOutput("A reset req_l", aReqL, 0);
    checkOutput("A reset dout", aDout, 0);
    checkOutput("B reset count", bCount, 0);
    rstA_n = 1'b1;
    rstB_n = 1'b1;

    $display("[TB] SUB with wrap-around");
    aReqR = 2'b11;
    applyStimulus(0, 10, 3, 2, 1);
    applyStimulus(0, 0, 1, 0, 1);
    waitDrain(0, 200, "A sub drain");

    $display("[TB] full FIFO with one idle consumer");
    aReqR = 2'b01;
    c0Start = aAckCnt0;
    c1Start = aAckCnt1;
    for (int i = 0; i < 5; i++) applyStimulus(0, i + 2, 1, 1, 1);
    k = 0;
    while (k < 100 && aCount != 3'd4) begin @(negedge clk); k++; end
    checkOutput("A full reached", k < 100, 1);
    repeat (6) @(negedge clk);
    checkOutput("A full count", aCount, 4);
    checkOutput("A full req_l", aReqL, 0);
    checkOutput("A c0 single ack", aAckCnt0 - c0Start, 1);
    checkOutput("A c1 no ack", aAckCnt1 - c1Start, 0);
`ifdef ASYNC_OP_STATS_EN
    s0 = aStallCnt;
    repeat (20) @(negedge clk);
    sd = aStallCnt - s0;
    checkOutput("A stall_cnt window", (sd >= 19 && sd <= 21), 1);
    checkOutput("A fire_cnt", aFireCnt, 6);
`else
    repeat (20) @(negedge clk);
`endif
    checkOutput("A held count", aCount, 4);
    aReqR = 2'b11;
    waitDrain(0, 300, "A full drain");
    checkOutput("A c0 total acks", aAckCnt0 - c0Start, 5);
    checkOutput("A c1 total acks", aAckCnt1 - c1Start, 5);
    checkOutput("A empty count", aCount, 0);

    $display("[TB] reset mid-operation");
    aReqR = 2'b00;
    for (int i = 0; i < 3; i++) applyStimulus(0, 7 + i, 1, 1, 0);
    k = 0;
    while (k < 100 && aCount != 3'd3) begin @(negedge clk); k++; end
    checkOutput("A count 3 reached", k < 100, 1);
    aMask = 3'b001;
    applyStimulus(0, 50, 1, 1, 0);
    k = 0;
    while (k < 50 && aRd[0] != aWr) begin @(negedge clk); k++; end
    checkOutput("A partial capture", k < 50, 1);
    repeat (2) @(negedge clk);
    checkOutput("A pre-reset count", aCount, 3);
    rstA_n = 1'b0;
    @(negedge clk);
    checkOutput("A mid reset count", aCount, 0);
    checkOutput("A mid reset ack_r", aAckR, 0);
    checkOutput("A mid reset req_l", aReqL, 0);
    checkOutput("A mid reset dout", aDout, 0);
    rstA_n = 1'b1;
    aFlushReq = ~aFlushReq;
    k = 0;
    while (k < 10 && aFlushAck != aFlushReq) begin @(negedge clk); k++; end
    aMask = 3'b111;
    aReqR = 2'b11;
    applyStimulus(0, 20, 5, 5, 1);
    waitDrain(0, 200, "A post-reset drain");
    checkOutput("A post-reset count", aCount, 0);

    $display("[TB] ADD latency and streaming");
    bReqR = 1'b1;
    applyStimulus(1, 3, 4, 0, 1);
    waitDrain(1, 100, "B add drain");
    bReqR = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1, 100 * (i + 1), i + 1, 0, 1);
    k = 0;
    while (k < 100 && bCount != 3'd3) begin @(negedge clk); k++; end
    checkOutput("B count 3 reached", k < 100, 1);
    for (int i = 0; i < 12; i++) begin
      x = $urandom;
      y = $urandom;
      applyStimulus(1, x, y, 0, 1);
    end
    bReqR = 1'b1;
    waitDrain(1, 600, "B stream drain");
    checkOutput("B max count", bMaxCnt <= 4, 1);
    repeat (2) @(negedge clk);
    checkOutput("B final count", bCount, 0);
`ifdef ASYNC_OP_STATS_EN
    checkOutput("B fire_cnt", bFireCnt, 16);
    checkOutput("B stall_cnt nonzero", bStallCnt > 0, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
